// File: rtl/ethernet_tx_buffer.sv
// Transmit packet buffer: MMIO byte/half/word writes into an MTU-sized buffer,
// then streamed to the MAC as bytes with valid/ready/last and a TX event bit.
module ethernet_tx_buffer #(
  parameter int eth_mtu_p    = 2048,
  parameter int data_width_p = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             packet_wvalid_i,
  input  logic [$clog2(eth_mtu_p)-1:0]     packet_waddr_i,
  input  logic [data_width_p-1:0]          packet_wdata_i,
  input  logic [1:0]                       packet_wdata_size_i,
  input  logic                             packet_wsize_valid_i,
  input  logic [$clog2(eth_mtu_p+1)-1:0]   packet_wsize_i,
  input  logic                             packet_send_i,
  output logic                             packet_req_o,
  input  logic                             tx_interrupt_clear_i,
  input  logic                             tx_interrupt_enable_i,
  input  logic                             tx_interrupt_enable_v_i,
  output logic                             tx_interrupt_pending_o,
  output logic                             tx_interrupt_o,
  output logic [7:0]                       tx_data_o,
  output logic                             tx_valid_o,
  output logic                             tx_last_o,
  input  logic                             tx_ready_i
);

  localparam int AW    = $clog2(eth_mtu_p);
  localparam int LW    = $clog2(eth_mtu_p + 1);
  localparam int DEPTH = eth_mtu_p / 4;
  localparam logic [LW-1:0] MTU = LW'(eth_mtu_p);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;

  logic [LW-1:0]           len_r;
  logic [LW-1:0]           cnt;
  logic [LW-1:0]           rd_word;
  logic [LW-1:0]           nwords;
  logic [1:0]              fcnt;
  logic                    wr_ptr, rd_ptr;
  logic                    pending_r, enable_r;
  logic [31:0]             fifo_q [2];
  logic [7:0]              mem [4][DEPTH];
  logic [3:0]              wen;
  logic [data_width_p-1:0] wshift;
  logic [AW-3:0]           raddr;
  logic [31:0]             head;
  logic                    hs, pop, fetch, done, last_byte;

  // Write lane decode; misaligned or size-3 writes leave wen all zero.
  always_comb begin
    wen    = '0;
    wshift = packet_wdata_i << {packet_waddr_i[1:0], 3'b000};
    if (packet_wvalid_i && state == IDLE) begin
      case (packet_wdata_size_i)
        2'd0: wen[packet_waddr_i[1:0]] = 1'b1;
        2'd1: if (!packet_waddr_i[0]) wen = packet_waddr_i[1] ? 4'b1100 : 4'b0011;
        2'd2: if (packet_waddr_i[1:0] == 2'd0) wen = '1;
        default: wen = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen[i]) mem[i][packet_waddr_i[AW-1:2]] <= wshift[8*i +: 8];
    end
  end

  // The synchronous read lands directly in a staging slot, so byte 0 is
  // presented the cycle after the first read is issued.
  assign raddr = rd_word[AW-3:0];
  always_ff @(posedge clk_i) begin
    if (fetch) fifo_q[wr_ptr] <= {mem[3][raddr], mem[2][raddr], mem[1][raddr], mem[0][raddr]};
  end

  assign head      = fifo_q[rd_ptr];
  assign nwords    = (len_r + LW'(3)) >> 2;
  assign last_byte = (cnt == len_r - LW'(1));
  assign tx_valid_o = (state == SEND) && (fcnt != 2'd0);
  assign tx_last_o  = tx_valid_o && last_byte;
  assign tx_data_o  = tx_valid_o ? head[{cnt[1:0], 3'b000} +: 8] : '0;
  assign hs         = tx_valid_o && tx_ready_i;
  assign pop        = hs && (cnt[1:0] == 2'd3 || tx_last_o);
  assign fetch      = (state == SEND) && (rd_word < nwords) && (fcnt != 2'd2 || pop);
  assign done       = (state == SEND && hs && tx_last_o) ||
                      (state == IDLE && packet_send_i && len_r == '0);

  assign packet_req_o           = (state == IDLE);
  assign tx_interrupt_pending_o = pending_r;
  assign tx_interrupt_o         = pending_r && enable_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (packet_send_i && len_r != '0) state_n = SEND;
      SEND: if (hs && tx_last_o) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_r     <= '0;
      cnt       <= '0;
      rd_word   <= '0;
      fcnt      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      pending_r <= 1'b0;
      enable_r  <= 1'b0;
    end else begin
      if (state == IDLE && packet_wsize_valid_i)
        len_r <= (packet_wsize_i > MTU) ? MTU : packet_wsize_i;
      if (state_n != SEND) begin
        cnt     <= '0;
        rd_word <= '0;
        fcnt    <= '0;
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
      end else begin
        if (hs)    cnt <= cnt + LW'(1);
        if (fetch) begin
          rd_word <= rd_word + LW'(1);
          wr_ptr  <= ~wr_ptr;
        end
        if (pop)   rd_ptr <= ~rd_ptr;
        fcnt <= fcnt + {1'b0, fetch} - {1'b0, pop};
      end
      if (done)                      pending_r <= 1'b1;
      else if (tx_interrupt_clear_i) pending_r <= 1'b0;
      if (tx_interrupt_enable_v_i)   enable_r  <= tx_interrupt_enable_i;
    end
  end

endmodule

// File: tb/tb_ethernet_tx_buffer.sv
// Scoreboard bench for ethernet_tx_buffer: a byte-array reference model queues
// expected stream bytes on send; a negedge monitor pops and compares.
module tb_ethernet_tx_buffer;
  localparam int MTU = 2048;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        packet_wvalid_i = 1'b0;
  logic [10:0] packet_waddr_i = '0;
  logic [31:0] packet_wdata_i = '0;
  logic [1:0]  packet_wdata_size_i = '0;
  logic        packet_wsize_valid_i = 1'b0;
  logic [11:0] packet_wsize_i = '0;
  logic        packet_send_i = 1'b0;
  logic        packet_req_o;
  logic        tx_interrupt_clear_i = 1'b0;
  logic        tx_interrupt_enable_i = 1'b0;
  logic        tx_interrupt_enable_v_i = 1'b0;
  logic        tx_interrupt_pending_o;
  logic        tx_interrupt_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_last_o;
  logic        tx_ready_i = 1'b1;

  always #5 clk = ~clk;

  ethernet_tx_buffer #(.eth_mtu_p(MTU), .data_width_p(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .packet_wvalid_i(packet_wvalid_i), .packet_waddr_i(packet_waddr_i),
    .packet_wdata_i(packet_wdata_i), .packet_wdata_size_i(packet_wdata_size_i),
    .packet_wsize_valid_i(packet_wsize_valid_i), .packet_wsize_i(packet_wsize_i),
    .packet_send_i(packet_send_i), .packet_req_o(packet_req_o),
    .tx_interrupt_clear_i(tx_interrupt_clear_i), .tx_interrupt_enable_i(tx_interrupt_enable_i),
    .tx_interrupt_enable_v_i(tx_interrupt_enable_v_i),
    .tx_interrupt_pending_o(tx_interrupt_pending_o), .tx_interrupt_o(tx_interrupt_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
    .tx_ready_i(tx_ready_i)
  );

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t        exp_q[$];
  logic [7:0]  mem_m [MTU];
  int          len_m = 0;
  bit          en_m = 1'b0;
  int          ready_mode = 0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MAC backpressure: always ready, or a coin flip each cycle.
  always @(posedge clk) begin
    #1;
    tx_ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
  end

  bit         stall = 1'b0;
  logic [7:0] held_d;
  logic       held_l;
  always @(negedge clk) begin
    if (reset_i) stall = 1'b0;
    else begin
      if (stall) begin
        check("stall_valid", 32'(tx_valid_o), 32'd1);
        check("stall_data", 32'(tx_data_o), 32'(held_d));
        check("stall_last", 32'(tx_last_o), 32'(held_l));
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_valid_o), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", 32'(tx_data_o), 32'(e.d));
          check("last", 32'(tx_last_o), 32'(e.l));
        end
      end
      stall  = tx_valid_o && !tx_ready_i;
      held_d = tx_data_o;
      held_l = tx_last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(int a, logic [31:0] d, int sz);
    case (sz)
      0: mem_m[a] = d[7:0];
      1: if (a % 2 == 0) begin mem_m[a] = d[7:0]; mem_m[a+1] = d[15:8]; end
      2: if (a % 4 == 0) for (int j = 0; j < 4; j++) mem_m[a+j] = d[8*j +: 8];
      default: ;
    endcase
  endtask

  task automatic wr(int a, logic [31:0] d, int sz, bit upd);
    packet_wvalid_i = 1'b1;
    packet_waddr_i = 11'(a);
    packet_wdata_i = d;
    packet_wdata_size_i = 2'(sz);
    if (upd) model_write(a, d, sz);
    tick();
    packet_wvalid_i = 1'b0;
  endtask

  task automatic set_len(int n, bit upd);
    packet_wsize_valid_i = 1'b1;
    packet_wsize_i = 12'(n);
    if (upd) len_m = (n > MTU) ? MTU : n;
    tick();
    packet_wsize_valid_i = 1'b0;
  endtask

  task automatic set_enable(bit v);
    tx_interrupt_enable_v_i = 1'b1;
    tx_interrupt_enable_i = v;
    en_m = v;
    tick();
    tx_interrupt_enable_v_i = 1'b0;
  endtask

  task automatic queue_packet();
    for (int k = 0; k < len_m; k++) exp_q.push_back('{d: mem_m[k], l: (k == len_m - 1)});
  endtask

  task automatic finish_send();
    int cycles = 0;
    while (!packet_req_o && cycles < 6000) begin
      tick();
      cycles++;
    end
    check("req_after_done", 32'(packet_req_o), 32'd1);
    if (ready_mode == 0) check("burst_cycles", 32'(cycles), 32'(len_m));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pending_done", 32'(tx_interrupt_pending_o), 32'd1);
    check("irq_done", 32'(tx_interrupt_o), 32'(en_m));
  endtask

  task automatic do_send();
    tx_interrupt_clear_i = 1'b1;
    tick();
    tx_interrupt_clear_i = 1'b0;
    check("pending_cleared", 32'(tx_interrupt_pending_o), 32'd0);
    queue_packet();
    packet_send_i = 1'b1;
    check("req_before_send", 32'(packet_req_o), 32'd1);
    tick();
    packet_send_i = 1'b0;
    if (len_m == 0) begin
      check("zero_len_pending", 32'(tx_interrupt_pending_o), 32'd1);
      check("zero_len_req", 32'(packet_req_o), 32'd1);
      check("zero_len_irq", 32'(tx_interrupt_o), 32'(en_m));
    end else begin
      check("req_low_t1", 32'(packet_req_o), 32'd0);
      check("valid_low_t1", 32'(tx_valid_o), 32'd0);
      tick();
      check("first_valid_t2", 32'(tx_valid_o), 32'd1);
      finish_send();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    reset_i = 1'b0;
    check("rst_req", 32'(packet_req_o), 32'd1);
    check("rst_valid", 32'(tx_valid_o), 32'd0);
    check("rst_last", 32'(tx_last_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_pending", 32'(tx_interrupt_pending_o), 32'd0);
    check("rst_irq", 32'(tx_interrupt_o), 32'd0);

    // Basic word writes streamed at full rate.
    wr(0, 32'h44332211, 2, 1);
    wr(4, 32'h88776655, 2, 1);
    set_len(6, 1);
    do_send();

    // Byte/half writes, misaligned half and size-3 writes dropped.
    wr(1, 32'h000000AB, 0, 1);
    wr(2, 32'h0000CDEF, 1, 1);
    wr(1, 32'h00009999, 1, 1);
    wr(0, 32'h77777777, 3, 1);
    wr(2, 32'h55555555, 2, 1);
    set_len(4, 1);
    do_send();

    // Full-MTU incrementing pattern under random backpressure; length clamped.
    for (int w = 0; w < MTU / 4; w++) begin
      logic [31:0] d;
      for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'((4 * w + j) % 256);
      wr(4 * w, d, 2, 1);
    end
    ready_mode = 1;
    set_len(3000, 1);
    do_send();

    // Zero-length send, interrupt enable, clear colliding with completion.
    ready_mode = 0;
    set_len(0, 1);
    set_enable(1'b1);
    do_send();
    tx_interrupt_clear_i = 1'b1;
    packet_send_i = 1'b1;
    tick();
    tx_interrupt_clear_i = 1'b0;
    packet_send_i = 1'b0;
    check("set_wins_pending", 32'(tx_interrupt_pending_o), 32'd1);
    check("set_wins_irq", 32'(tx_interrupt_o), 32'd1);
    set_enable(1'b0);
    check("irq_disabled", 32'(tx_interrupt_o), 32'd0);
    check("pending_kept", 32'(tx_interrupt_pending_o), 32'd1);

    // Send, length and buffer writes while a packet is in flight are ignored.
    for (int k = 0; k < 4; k++) wr(4 * k, $urandom, 2, 1);
    set_len(16, 1);
    ready_mode = 1;
    queue_packet();
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    check("inflight_req", 32'(packet_req_o), 32'd0);
    wr(8, 32'hDEADBEEF, 2, 0);
    wr(12, 32'hCAFEF00D, 2, 0);
    set_len(3, 0);
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    finish_send();
    do_send();

    // Reset mid-packet aborts, then the buffer replays intact.
    queue_packet();
    packet_send_i = 1'b1;
    tick();
    packet_send_i = 1'b0;
    repeat (4) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    len_m = 0;
    en_m = 1'b0;
    check("abort_valid", 32'(tx_valid_o), 32'd0);
    check("abort_req", 32'(packet_req_o), 32'd1);
    check("abort_pending", 32'(tx_interrupt_pending_o), 32'd0);
    repeat (3) tick();
    check("abort_quiet", 32'(tx_valid_o), 32'd0);
    set_len(16, 1);
    do_send();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ethernet_tx_buffer.md
# ethernet_tx_buffer

Transmit packet buffer and serializer directly downstream of `ethernet_control_unit`. It accepts byte-, half- and word-sized MMIO writes into a local MTU-sized packet buffer, latches the packet length, and on a send command streams the packet to the MAC as a byte stream with valid/ready/last. It also owns the TX-ready status bit and the TX event-pending/enable state that the control unit reads and writes.

## Interface
- `eth_mtu_p`, 2048: buffer size in bytes; power of two, multiple of 4, ≤ 2048.
- `data_width_p`, 32: write-data width; only 32 is supported.
- `clk_i`  in  1: clock.
- `reset_i`  in  1: synchronous, active-high reset.
- `packet_wvalid_i`  in  1: buffer write strobe.
- `packet_waddr_i`  in  $clog2(eth_mtu_p): byte address of the write.
- `packet_wdata_i`  in  data_width_p: write data, right-justified (bits [7:0] carry the lowest-addressed byte).
- `packet_wdata_size_i`  in  2: write size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is dropped.
- `packet_wsize_valid_i`  in  1: length write strobe.
- `packet_wsize_i`  in  $clog2(eth_mtu_p+1): packet length in bytes.
- `packet_send_i`  in  1: start-transmit pulse.
- `packet_req_o`  out  1: idle and ready to accept a send.
- `tx_interrupt_clear_i`  in  1: clears the pending bit.
- `tx_interrupt_enable_i`  in  1: new enable value.
- `tx_interrupt_enable_v_i`  in  1: enable write strobe.
- `tx_interrupt_pending_o`  out  1: a transmit has completed.
- `tx_interrupt_o`  out  1: pending AND enable.
- `tx_data_o`  out  8: stream byte.
- `tx_valid_o`  out  1: stream valid.
- `tx_last_o`  out  1: marks the final byte of the packet.
- `tx_ready_i`  in  1: MAC accepts the byte.

## Operation
- **Storage**
  - Four byte-lane memories, each eth_mtu_p/4 deep, indexed by waddr[msb:2].
  - Synchronous read, one read port shared by all lanes.
- **Writes**
  - Accepted only in IDLE; dropped silently while SEND is in progress.
  - Size 0 writes lane waddr[1:0] with wdata[7:0].
  - Size 1 requires waddr[0]=0 and writes lanes waddr[1:0] and waddr[1:0]+1 with wdata[15:0].
  - Size 2 requires waddr[1:0]=0 and writes all four lanes.
  - A misaligned write or size 3 is dropped; no partial write occurs.
- **Length register** (`len_r`)
  - Loaded on packet_wsize_valid_i in IDLE; values above eth_mtu_p are clamped to eth_mtu_p.
  - Ignored while in SEND.
- **State machine: IDLE → SEND → IDLE**
  - IDLE: packet_req_o=1.
  - packet_send_i in IDLE with len_r=0: stay in IDLE, emit no bytes, set pending next cycle.
  - packet_send_i in IDLE with len_r>0: go to SEND and load byte counter cnt=0.
  - packet_send_i in SEND is ignored.
  - SEND: bytes 0 .. len_r-1 are emitted in address order; byte k comes from lane k[1:0] of word k>>2.
  - tx_last_o=1 exactly when cnt = len_r-1.
  - A handshake on the last byte returns to IDLE and sets pending.
- **Prefetch**
  - A two-entry word staging register keeps one word ahead of the stream, so that continuous tx_ready_i=1 sustains one byte per cycle.
- **Stream rules**
  - Once tx_valid_o=1, tx_data_o and tx_last_o hold until tx_ready_i.
  - tx_valid_o never drops without a handshake.
- **Interrupt state**
  - Pending is set on completion and cleared by tx_interrupt_clear_i.
  - Simultaneous set and clear: set wins.
  - Enable register loads on tx_interrupt_enable_v_i.
- **Reset values**
  - State=IDLE, packet_req_o=1.
  - tx_valid_o=0, tx_last_o=0, tx_data_o=0.
  - Pending=0, enable=0, tx_interrupt_o=0, len_r=0, cnt=0.
  - Buffer contents are not cleared.
  - Reset during SEND aborts the packet: tx_valid_o=0 the cycle after reset; no completion and no pending.

## Timing
- Write at cycle t is visible to a send issued at t+1 or later.
- packet_send_i at cycle t (len>0):
  - packet_req_o=0 at t+1;
  - first word read issued at t+1;
  - tx_valid_o=1 with byte 0 at t+2.
- With tx_ready_i held at 1, an N-byte packet occupies cycles t+2 .. t+N+1.
- Last-byte handshake at cycle L gives packet_req_o=1 and pending=1 at L+1.
- Zero-length send at t gives pending=1 at t+1; packet_req_o stays 1 throughout.
- tx_interrupt_o is registered-consistent with pending and enable: it updates in the same cycle either of them changes.

## Test plan
- Word writes 0x44332211 @0 and 0x88776655 @4, len=6, send, ready=1 → stream 11,22,33,44,55,66 on consecutive cycles, last on 66, first valid at send+2, then pending=1 and req=1.
- Byte write 0xAB @1, half write 0xCDEF @2, half write @1 (misaligned, dropped), len=4 → stream 11,AB,EF,CD.
- Random tx_ready_i backpressure over a 2048-byte incrementing pattern → every byte correct, data held stable while stalled, exactly one last, on byte 2047.
- len=0 send → no tx_valid_o, pending=1 next cycle; enable=1 → tx_interrupt_o=1; clear in the same cycle as a new completion → pending stays 1.
- Send issued during SEND, and length/buffer writes during SEND → ignored; the packet in flight is unchanged.
- reset_i asserted mid-packet → tx_valid_o=0, req=1, pending=0 next cycle; a new send afterwards streams the original buffer contents.
